// File: rtl/uart_rx_top.sv
// Oversampled UART receiver: start, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// The received byte is held on P_DATA; data_valid stays high until the next start detection.
module uart_rx_top #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      PAR_TYP,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      RX_IN,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid
);

  // state  | meaning
  // IDLE   | line idle, waiting for a low level
  // START  | start bit; a high mid-bit sample is treated as a glitch
  // DATA   | shifting in data bits LSB-first
  // PARITY | checking the parity bit
  // STOP   | stop bit; result committed at its mid-bit sample
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t state, state_nxt;

  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] half;
  logic [BW-1:0]             bit_cnt;
  logic [DATA_WIDTH-1:0]     shift_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic                      par_err;
  logic                      samp0;
  logic                      samp1;
  logic                      bit_val;
  logic                      exp_par;
  logic                      last_edge;
  logic                      at_sample;

  assign half      = {1'b0, prescale_q[PRESCALE_WIDTH-1:1]};
  assign last_edge = (edge_cnt == prescale_q - PRESCALE_WIDTH'(1));
  assign at_sample = (edge_cnt == half + PRESCALE_WIDTH'(1));
  // Third vote comes straight from the line at the last sample point
  assign bit_val   = (samp0 & samp1) | (samp0 & RX_IN) | (samp1 & RX_IN);
  assign exp_par   = par_typ_q ? ~(^shift_q) : ^shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!RX_IN) state_nxt = START;
      START: begin
        if (at_sample && bit_val) state_nxt = IDLE;
        else if (last_edge)       state_nxt = DATA;
      end
      DATA:    if (last_edge && bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (last_edge) state_nxt = STOP;
      STOP:    if (at_sample) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err    <= 1'b0;
      samp0      <= 1'b0;
      samp1      <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
    end else if (state == IDLE) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      par_err  <= 1'b0;
      if (!RX_IN) begin
        // This cycle is edge 0 of the start bit, so the counter resumes at 1
        prescale_q <= Prescale;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        edge_cnt   <= PRESCALE_WIDTH'(1);
        data_valid <= 1'b0;
      end
    end else begin
      edge_cnt <= last_edge ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
      if (edge_cnt == half - PRESCALE_WIDTH'(1)) samp0 <= RX_IN;
      if (edge_cnt == half)                      samp1 <= RX_IN;
      if (state == DATA && last_edge)            bit_cnt <= bit_cnt + BW'(1);
      if (at_sample) begin
        case (state)
          DATA:   shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
          PARITY: par_err <= (bit_val != exp_par);
          STOP: begin
            if (bit_val && !par_err) begin
              P_DATA     <= shift_q;
              data_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_top.sv
// Scoreboard bench for uart_rx_top: the driver queues the expected outputs per frame,
// the monitor pops and compares when the driver marks the end of each frame.
module tb_uart_rx_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       PAR_TYP;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       RX_IN;
  logic [7:0] P_DATA;
  logic       data_valid;

  uart_rx_top #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .PAR_TYP    (PAR_TYP),
    .PAR_EN     (PAR_EN),
    .Prescale   (Prescale),
    .RX_IN      (RX_IN),
    .P_DATA     (P_DATA),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   errors = 0;
  int   checks = 0;
  int   valid_rises = 0;

  always @(posedge data_valid) if (!rst) valid_rises++;

  task automatic expect_out(input logic v, input logic [7:0] d, input string tag);
    exp_t e;
    e.v = v; e.d = d; e.tag = tag;
    exp_q.push_back(e);
    -> chk_ev;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(chk_ev);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: check requested with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (data_valid !== e.v) begin
          errors++;
          $display("FAIL %s data_valid: got %b expected %b", e.tag, data_valid, e.v);
        end
        checks++;
        if (P_DATA !== e.d) begin
          errors++;
          $display("FAIL %s P_DATA: got %h expected %h", e.tag, P_DATA, e.d);
        end
      end
    end
  end

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge clk);
  endtask

  // Sends a full frame; mid_presc != 0 changes the Prescale input after the start bit
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic bad_par, input logic stop_val, input int p,
                            input int mid_presc);
    logic pbit;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    Prescale = 6'(p);
    send_bit(1'b0, p);
    if (mid_presc != 0) Prescale = 6'(mid_presc);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    pbit = (ptyp ? ~(^d) : ^d) ^ bad_par;
    if (pen) send_bit(pbit, p);
    send_bit(stop_val, p);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : driver
    rst = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    #1;
    expect_out(1'b0, 8'h00, "reset_now");
    @(negedge clk);
    expect_out(1'b0, 8'h00, "reset_held");
    rst = 1'b0;
    idle(4);

    send_frame(8'h45, 1'b0, 1'b0, 1'b0, 1'b1, 8, 0);
    expect_out(1'b1, 8'h45, "no_parity_45");
    idle(16);

    send_frame(8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, 8, 0);
    expect_out(1'b1, 8'hAA, "odd_parity_AA");
    idle(16);

    send_frame(8'hA8, 1'b1, 1'b0, 1'b0, 1'b1, 8, 0);
    expect_out(1'b1, 8'hA8, "even_parity_A8");
    idle(16);

    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8, 0);
    expect_out(1'b0, 8'hA8, "bad_parity_3C");
    idle(16);

    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8, 0);
    expect_out(1'b0, 8'hA8, "bad_stop_11");
    idle(32);

    Prescale = 6'd16;
    RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    idle(40);
    expect_out(1'b0, 8'hA8, "glitch");

    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 16, 0);
    expect_out(1'b1, 8'hF0, "presc16_F0");
    idle(32);

    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8, 16);
    expect_out(1'b1, 8'h5A, "presc_change_5A");
    idle(2);

    Prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    expect_out(1'b0, 8'h00, "reset_mid_frame");
    @(negedge clk);
    rst = 1'b0;
    idle(16);
    expect_out(1'b0, 8'h00, "after_reset_idle");

    @(negedge clk);
    checks++;
    if (valid_rises != 5) begin
      errors++;
      $display("FAIL valid_rises: got %0d expected %0d", valid_rises, 5);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
- UART receiver top level: oversampled serial input RX_IN, 8-bit LSB-first frames (start, 8 data, optional parity, 1 stop).
- Outputs the received byte on P_DATA with a data_valid flag.
- Sits at the serial-input edge of the UART subsystem; Prescale (clk cycles per bit), PAR_EN and PAR_TYP come from configuration registers.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_WIDTH, 6, width of the Prescale input.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- PAR_TYP  input  1  parity type: 0 = even, expected bit = XOR of data; 1 = odd, expected bit = XNOR of data
- PAR_EN  input  1  1 = frame carries a parity bit after the data bits
- Prescale  input  6  clk cycles per serial bit; legal range even values 6..62, nominal 8/16/32
- RX_IN  input  1  serial line, idle high
- P_DATA  output  8  last good received byte
- data_valid  output  1  high while P_DATA holds a byte from a frame that passed all checks

Behaviour:
- Reset, asynchronous active-high, forcing:
  - FSM to IDLE
  - counters to 0
  - P_DATA = 8'h00, data_valid = 0
- RX_IN is sampled directly on clk with no synchronizer.
- Prescale, PAR_EN and PAR_TYP are latched at start detection and are stable for the whole frame.
- Edge counter:
  - Counts 0..Prescale-1 within each bit period, then wraps to 0 and advances the bit counter.
  - Edge 0 is the first cycle RX_IN is seen low in IDLE.
- Sampled bit value = majority of RX_IN at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on RX_IN==0 go to START and clear data_valid; otherwise hold outputs.
  - START: after the mid-bit sample, sample 1 (glitch) returns to IDLE with outputs unchanged; sample 0 continues. Leave at end of bit period.
  - DATA: shift the 8 sampled bits LSB-first into an internal shift register. After bit 7's period go to PARITY if PAR_EN, else STOP.
  - PARITY: compare the sample with the expected bit; mismatch sets an internal parity-error flag. Go to STOP at end of period.
  - STOP: at the mid-bit sample (count Prescale/2+1), sample 1 and no parity error means P_DATA <= shift register and data_valid <= 1 on the next clk. Any failure leaves P_DATA unchanged, data_valid = 0. Return to IDLE immediately after the sample, without waiting for the end of the stop bit.
- data_valid:
  - Stays high (level, not a pulse) until the next start detection or reset.
  - Is therefore high one full stop-bit period after the stop bit begins.
- Back-to-back frames: a falling RX_IN seen in IDLE after the stop sample starts a new frame; at most 1 cycle of idle is needed.
- Reset mid-frame aborts the frame; outputs go to reset values.
- Prescale changes mid-frame are ignored until the next frame.

Test Plan:
- Reset: drive rst=1 for 1 cycle with RX_IN=1 -> P_DATA==8'h00, data_valid==0 immediately and while held.
- No parity: PAR_EN=0, Prescale=8, send 8'h45 LSB-first, 8 cycles per bit, then stop bit -> at the end of the stop bit, data_valid==1 and P_DATA==8'h45.
- Odd parity: PAR_EN=1, PAR_TYP=1, Prescale=8, send 8'hAA with parity bit ~^8'hAA = 1 -> data_valid==1, P_DATA==8'hAA.
- Even parity: PAR_EN=1, PAR_TYP=0, Prescale=8, send 8'hA8 with parity bit ^8'hA8 = 1 -> data_valid==1, P_DATA==8'hA8.
- Errors, two cases, each with P_DATA keeping its previous byte:
  - Send 8'h3C with the wrong parity bit -> data_valid==0.
  - Send a frame with stop bit = 0 -> data_valid==0.
- Glitch and Prescale=16:
  - 2-cycle low pulse on idle RX_IN -> no frame, outputs unchanged.
  - Then send 8'hF0 at Prescale=16 -> P_DATA==8'hF0, data_valid==1.
